// File: rtl/phase_accum_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : phase_accum_scheduler
// Purpose  : On each tick, runs all CHANNELS phase accumulators through one
//            external adder. Each channel uses the adder for one cycle.
// Revision : 1.0
// ============================================================================
module phase_accum_scheduler #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_chan,
  input  logic [WIDTH-1:0] cfg_inc,
  input  logic             cfg_clr,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_chan,
  output logic [WIDTH-1:0] out_phase,
  output logic             out_wrap,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CH_W-1:0] LAST_CHAN = CH_W'(CHANNELS - 1);

  state_t           state;
  state_t           state_next;
  logic [CH_W-1:0]  chan_idx;
  logic             pending;
  logic [WIDTH-1:0] phase [CHANNELS];
  logic [WIDTH-1:0] inc   [CHANNELS];
  logic             last_chan;
  logic             chan_in_range;
  logic             cfg_accept;

  // Only a non-power-of-two channel count can see out-of-range indices.
  generate
    if ((1 << CH_W) == CHANNELS) begin : g_full_range
      assign chan_in_range = 1'b1;
    end else begin : g_partial_range
      assign chan_in_range = (32'(cfg_chan) < 32'(CHANNELS));
    end
  endgenerate

  assign last_chan  = (chan_idx == LAST_CHAN);
  assign cfg_ready  = (state == IDLE);
  assign busy       = (state == RUN);
  assign cfg_accept = cfg_valid && (state == IDLE) && chan_in_range;
  assign add_cin    = 1'b0;
  assign add_a      = (state == RUN) ? phase[chan_idx] : '0;
  assign add_b      = (state == RUN) ? inc[chan_idx]   : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick || pending) state_next = RUN;
      RUN:     if (last_chan)       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chan_idx  <= '0;
      pending   <= 1'b0;
      overrun   <= 1'b0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_phase <= '0;
      out_wrap  <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        phase[i] <= '0;
        inc[i]   <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (state == IDLE) begin
        // Any pending request is consumed by the sweep that starts now.
        chan_idx <= '0;
        pending  <= 1'b0;
        if (cfg_accept) begin
          inc[cfg_chan] <= cfg_inc;
          if (cfg_clr) begin
            phase[cfg_chan] <= '0;
          end
        end
      end else begin
        phase[chan_idx] <= add_sum;
        out_valid       <= 1'b1;
        out_chan        <= chan_idx;
        out_phase       <= add_sum;
        out_wrap        <= add_cout;
        done            <= last_chan;
        chan_idx        <= last_chan ? '0 : chan_idx + CH_W'(1);
        if (tick) begin
          if (pending) begin
            overrun <= 1'b1;
          end else begin
            pending <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phase_accum_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_accum_scheduler
// Purpose  : Self-checking bench for phase_accum_scheduler. It uses a
//            behavioural adder and a reference model of each sweep.
// Revision : 1.0
// ============================================================================
module tb_phase_accum_scheduler;

  localparam int WIDTH = 16;
  localparam int CH    = 4;
  localparam int CH_W  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan = '0;
  logic [WIDTH-1:0] cfg_inc = '0;
  logic             cfg_clr = 1'b0;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  logic             out_valid, out_wrap, busy, done, overrun;
  logic [CH_W-1:0]  out_chan;
  logic [WIDTH-1:0] out_phase;

  phase_accum_scheduler #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_inc(cfg_inc), .cfg_clr(cfg_clr),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_chan(out_chan), .out_phase(out_phase),
    .out_wrap(out_wrap), .busy(busy), .done(done), .overrun(overrun)
  );

  // The shared adder outside the block
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  always #5 clk = ~clk;

  typedef struct {
    int               chan;
    logic [WIDTH-1:0] phase;
    logic             wrap;
    logic             done;
    int               cyc;
  } rep_t;

  rep_t             got[$];
  rep_t             exp[$];
  logic [WIDTH-1:0] phase_m [CH];
  logic [WIDTH-1:0] inc_m   [CH];
  int               cyc = 0;
  int               stray_done = 0;
  int               checks = 0;
  int               errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rep_t r;
    if (out_valid === 1'b1) begin
      r.chan = int'(out_chan); r.phase = out_phase; r.wrap = out_wrap;
      r.done = done; r.cyc = cyc;
      got.push_back(r);
    end else if (done === 1'b1) begin
      stray_done++;
    end
  end

  // One full sweep: every channel advances by its increment, modulo 2^WIDTH.
  function automatic void model_sweep();
    rep_t r;
    for (int c = 0; c < CH; c++) begin
      int unsigned s = int'(phase_m[c]) + int'(inc_m[c]);
      r.chan = c; r.phase = WIDTH'(s); r.wrap = (s >= 32'h10000);
      r.done = (c == CH - 1); r.cyc = 0;
      exp.push_back(r);
      phase_m[c] = WIDTH'(s);
    end
  endfunction

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; cfg_valid = 1'b0; cfg_clr = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    for (int c = 0; c < CH; c++) begin phase_m[c] = '0; inc_m[c] = '0; end
    got.delete(); exp.delete(); stray_done = 0;
  endtask

  task automatic cfg_write(input int c, input logic [WIDTH-1:0] v, input logic clr);
    cfg_valid = 1'b1; cfg_chan = CH_W'(c); cfg_inc = v; cfg_clr = clr;
    inc_m[c] = v;
    if (clr) phase_m[c] = '0;
    cycle();
    cfg_valid = 1'b0; cfg_clr = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1; cycle(); tick = 1'b0;
    model_sweep();
    repeat (CH + 2) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b1; cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_inc = 16'h1111;
    repeat (2) cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_chan !== '0) begin errors++; $display("FAIL reset_out_chan got %0d want 0", out_chan); end
    checks++; if (out_phase !== '0) begin errors++; $display("FAIL reset_out_phase got %h want 0", out_phase); end
    checks++; if (out_wrap !== 1'b0) begin errors++; $display("FAIL reset_out_wrap got %b want 0", out_wrap); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    checks++; if (add_a !== '0 || add_b !== '0) begin errors++; $display("FAIL reset_adder_ops got %h/%h want 0/0", add_a, add_b); end
    checks++; if (add_cin !== 1'b0) begin errors++; $display("FAIL reset_add_cin got %b want 0", add_cin); end
    rst = 1'b0; tick = 1'b0; cfg_valid = 1'b0;
    got.delete(); exp.delete(); stray_done = 0;
    for (int c = 0; c < CH; c++) begin phase_m[c] = '0; inc_m[c] = '0; end
    // The tick and config write seen under reset must have no effect.
    cycle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_tick_ignored busy got %b want 0", busy); end
    pulse_tick();
    checks++; if (got.size() != CH) begin errors++; $display("FAIL reset_sweep_count got %0d want %0d", got.size(), CH); end
    foreach (got[i]) begin
      checks++;
      if (got[i].phase !== '0) begin errors++; $display("FAIL reset_cfg_ignored chan %0d phase got %h want 0", got[i].chan, got[i].phase); end
    end
    got.delete(); exp.delete();
  endtask

  task automatic test_basic_sweep();
    do_reset();
    for (int c = 0; c < CH; c++) cfg_write(c, WIDTH'(c + 1), 1'b0);
    tick = 1'b1;
    for (int k = 0; k <= CH; k++) begin
      cycle(); tick = 1'b0;
      checks++; if (busy !== 1'(k < CH)) begin errors++; $display("FAIL basic_busy k=%0d got %b want %b", k, busy, k < CH); end
      checks++; if (cfg_ready !== 1'(k >= CH)) begin errors++; $display("FAIL basic_cfg_ready k=%0d got %b", k, cfg_ready); end
      checks++; if (out_valid !== 1'(k >= 1)) begin errors++; $display("FAIL basic_out_valid k=%0d got %b", k, out_valid); end
      checks++; if (done !== 1'(k == CH)) begin errors++; $display("FAIL basic_done k=%0d got %b", k, done); end
      if (k < CH) begin
        checks++;
        if (add_a !== '0 || add_b !== WIDTH'(k + 1)) begin errors++; $display("FAIL basic_operands k=%0d got %h/%h want 0/%h", k, add_a, add_b, k + 1); end
      end
      if (k >= 1) begin
        checks++;
        if (out_chan !== CH_W'(k - 1) || out_phase !== WIDTH'(k) || out_wrap !== 1'b0) begin
          errors++; $display("FAIL basic_report k=%0d got (%0d,%h,%b) want (%0d,%h,0)", k, out_chan, out_phase, out_wrap, k - 1, k);
        end
      end
    end
    cycle();
    checks++; if (add_a !== '0 || add_b !== '0) begin errors++; $display("FAIL basic_idle_operands got %h/%h want 0/0", add_a, add_b); end
    checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_idle_pulses got %b/%b want 0/0", out_valid, done); end
    got.delete();
  endtask

  task automatic test_wrap();
    do_reset();
    cfg_write(0, 16'h8000, 1'b0);
    for (int c = 1; c < CH; c++) cfg_write(c, WIDTH'($urandom), 1'b0);
    pulse_tick();
    pulse_tick();
    checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL wrap_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].chan !== exp[i].chan || got[i].phase !== exp[i].phase || got[i].wrap !== exp[i].wrap || got[i].done !== exp[i].done) begin
        errors++; $display("FAIL wrap_report %0d got (%0d,%h,%b,%b) want (%0d,%h,%b,%b)", i, got[i].chan, got[i].phase, got[i].wrap, got[i].done, exp[i].chan, exp[i].phase, exp[i].wrap, exp[i].done);
      end
    end
    if (got.size() > CH) begin
      checks++; if (got[0].phase !== 16'h8000 || got[0].wrap !== 1'b0) begin errors++; $display("FAIL wrap_first got %h/%b want 8000/0", got[0].phase, got[0].wrap); end
      checks++; if (got[CH].phase !== 16'h0000 || got[CH].wrap !== 1'b1) begin errors++; $display("FAIL wrap_second got %h/%b want 0000/1", got[CH].phase, got[CH].wrap); end
    end
    got.delete(); exp.delete();
  endtask

  task automatic test_collision();
    do_reset();
    cfg_write(1, 16'h0100, 1'b0);
    cfg_write(2, 16'h1234, 1'b0);
    pulse_tick();
    tick = 1'b1; cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_inc = 16'h0010; cfg_clr = 1'b1;
    inc_m[2] = 16'h0010; phase_m[2] = '0;
    cycle();
    tick = 1'b0; model_sweep();
    // Writes offered throughout RUN must be refused.
    cfg_chan = 2'd1; cfg_inc = 16'hFFFF; cfg_clr = 1'b1;
    for (int k = 0; k < CH; k++) begin
      checks++; if (cfg_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL coll_cfg_ready k=%0d got ready %b busy %b want 0/1", k, cfg_ready, busy); end
      cycle();
    end
    cfg_valid = 1'b0; cfg_clr = 1'b0;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL coll_ready_after got %b want 1", cfg_ready); end
    cycle();
    pulse_tick();
    checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL coll_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].chan !== exp[i].chan || got[i].phase !== exp[i].phase || got[i].wrap !== exp[i].wrap || got[i].done !== exp[i].done) begin
        errors++; $display("FAIL coll_report %0d got (%0d,%h,%b,%b) want (%0d,%h,%b,%b)", i, got[i].chan, got[i].phase, got[i].wrap, got[i].done, exp[i].chan, exp[i].phase, exp[i].wrap, exp[i].done);
      end
    end
    if (got.size() > CH + 2) begin
      checks++; if (got[CH + 2].phase !== 16'h0010) begin errors++; $display("FAIL coll_chan2 got %h want 0010", got[CH + 2].phase); end
    end
    got.delete(); exp.delete();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < CH; c++) cfg_write(c, WIDTH'($urandom), 1'b0);
    // Tick mid-sweep, then a tick on the final RUN edge.
    tick = 1'b1; cycle(); tick = 1'b0; cycle();
    tick = 1'b1; cycle(); tick = 1'b0;
    model_sweep(); model_sweep();
    repeat (2 * CH + 3) cycle();
    tick = 1'b1; cycle(); tick = 1'b0;
    repeat (CH - 1) cycle();
    tick = 1'b1; cycle(); tick = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap busy got %b want 0", busy); end
    cycle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart busy got %b want 1", busy); end
    model_sweep(); model_sweep();
    repeat (CH + 2) cycle();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun got %b want 0", overrun); end
    checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].chan !== exp[i].chan || got[i].phase !== exp[i].phase || got[i].wrap !== exp[i].wrap || got[i].done !== exp[i].done) begin
        errors++; $display("FAIL b2b_report %0d got (%0d,%h,%b,%b) want (%0d,%h,%b,%b)", i, got[i].chan, got[i].phase, got[i].wrap, got[i].done, exp[i].chan, exp[i].phase, exp[i].wrap, exp[i].done);
      end
      if (i > 0) begin
        checks++;
        if (got[i].cyc != got[i - 1].cyc + (got[i - 1].done ? ((i % (2 * CH)) == 0 ? got[i].cyc - got[i - 1].cyc : 2) : 1)) begin
          errors++; $display("FAIL b2b_spacing %0d got %0d want %0d", i, got[i].cyc - got[i - 1].cyc, got[i - 1].done ? 2 : 1);
        end
      end
    end
    got.delete(); exp.delete();
    // Three ticks inside one sweep lose one of them.
    tick = 1'b1; cycle(); cycle();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun_early got %b want 0", overrun); end
    cycle(); tick = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun_set got %b want 1", overrun); end
    repeat (2 * CH + 4) cycle();
    cfg_write(0, 16'h0001, 1'b1);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun_sticky got %b want 1", overrun); end
    checks++; if (got.size() != 2 * CH) begin errors++; $display("FAIL b2b_overrun_sweeps got %0d want %0d", got.size(), 2 * CH); end
    do_reset();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun_reset got %b want 0", overrun); end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] v;
    do_reset();
    for (int c = 0; c < CH; c++) cfg_write(c, WIDTH'($urandom), 1'b0);
    v = inc_m[0];
    tick = 1'b1; cycle(); tick = 1'b0;
    cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_pulses got v%b d%b b%b want 0", out_valid, done, busy); end
    checks++; if (out_chan !== '0 || out_phase !== '0 || out_wrap !== 1'b0) begin errors++; $display("FAIL mid_outputs got %0d/%h/%b want 0", out_chan, out_phase, out_wrap); end
    checks++; if (overrun !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_flags got ovr %b ready %b want 0/1", overrun, cfg_ready); end
    repeat (CH + 2) cycle();
    checks++; if (got.size() != 1 || stray_done != 0) begin errors++; $display("FAIL mid_aborted got %0d reports %0d done want 1/0", got.size(), stray_done); end
    if (got.size() >= 1) begin
      checks++; if (got[0].chan != 0 || got[0].phase !== v) begin errors++; $display("FAIL mid_first got (%0d,%h) want (0,%h)", got[0].chan, got[0].phase, v); end
    end
    got.delete(); exp.delete();
    for (int c = 0; c < CH; c++) begin phase_m[c] = '0; inc_m[c] = '0; end
    for (int c = 0; c < CH; c++) cfg_write(c, WIDTH'($urandom), 1'b0);
    pulse_tick();
    checks++; if (got.size() != CH) begin errors++; $display("FAIL mid_count got %0d want %0d", got.size(), CH); end
    for (int i = 0; i < got.size() && i < CH; i++) begin
      checks++;
      if (got[i].chan != i || got[i].phase !== inc_m[i] || got[i].wrap !== 1'b0) begin
        errors++; $display("FAIL mid_phase_eq_inc %0d got (%0d,%h,%b) want (%0d,%h,0)", i, got[i].chan, got[i].phase, got[i].wrap, i, inc_m[i]);
      end
    end
    got.delete(); exp.delete();
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 25; it++) begin
      int nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) cfg_write(int'($urandom_range(0, CH - 1)), WIDTH'($urandom), 1'($urandom_range(0, 3) == 0));
      tick = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        cfg_valid = 1'b1; cfg_chan = CH_W'($urandom_range(0, CH - 1)); cfg_inc = WIDTH'($urandom); cfg_clr = 1'($urandom_range(0, 1));
        inc_m[cfg_chan] = cfg_inc;
        if (cfg_clr) phase_m[cfg_chan] = '0;
      end
      cycle();
      tick = 1'b0;
      model_sweep();
      for (int k = 0; k < CH; k++) begin
        cfg_valid = 1'($urandom_range(0, 1)); cfg_chan = CH_W'($urandom_range(0, CH - 1));
        cfg_inc = WIDTH'($urandom); cfg_clr = 1'($urandom_range(0, 1));
        cycle();
      end
      cfg_valid = 1'b0; cfg_clr = 1'b0;
      repeat ($urandom_range(0, 2)) cycle();
    end
    repeat (2) cycle();
    checks++; if (got.size() != exp.size() || stray_done != 0) begin errors++; $display("FAIL rand_count got %0d want %0d stray %0d", got.size(), exp.size(), stray_done); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].chan !== exp[i].chan || got[i].phase !== exp[i].phase || got[i].wrap !== exp[i].wrap || got[i].done !== exp[i].done) begin
        errors++; $display("FAIL rand_report %0d got (%0d,%h,%b,%b) want (%0d,%h,%b,%b)", i, got[i].chan, got[i].phase, got[i].wrap, got[i].done, exp[i].chan, exp[i].phase, exp[i].wrap, exp[i].done);
      end
      if (i > 0 && !got[i - 1].done) begin
        checks++;
        if (got[i].cyc != got[i - 1].cyc + 1) begin errors++; $display("FAIL rand_gap %0d got %0d want 1", i, got[i].cyc - got[i - 1].cyc); end
      end
    end
    got.delete(); exp.delete();
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_wrap();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
